// File: rtl/psram_pkg.sv
// Shared types and constants for the UART-to-PSRAM command path.
package psram_pkg;

    localparam logic [7:0] OP_READ  = 8'h00;
    localparam logic [7:0] OP_WRITE = 8'h01;

    typedef logic [23:0] psram_addr_t;
    typedef logic [15:0] psram_data_t;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        ADDR0   = 4'd1,
        ADDR1   = 4'd2,
        ADDR2   = 4'd3,
        DATA0   = 4'd4,
        DATA1   = 4'd5,
        ISSUE   = 4'd6,
        WAIT_RD = 4'd7,
        TX_LO   = 4'd8,
        TX_HI   = 4'd9
    } dec_state_t;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_READ) || (b == OP_WRITE);
    endfunction

endpackage

// File: rtl/uart_cmd_decoder.sv
// Assembles UART bytes into PSRAM read/write requests and serialises read data back as two bytes.
//
// state   | meaning
// IDLE    | waiting for an opcode byte
// ADDR0-2 | collecting address bytes, LSB first
// DATA0-1 | collecting write data bytes, LSB first
// ISSUE   | request presented, waiting for i_cmd_rdy
// WAIT_RD | waiting for read data from the PSRAM controller
// TX_LO   | sending read data low byte
// TX_HI   | sending read data high byte
module uart_cmd_decoder
    import psram_pkg::*;
#(
    parameter int TIMEOUT_CYC = 20_000
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_vld,
    output logic        o_cmd_vld,
    input  logic        i_cmd_rdy,
    output logic        o_cmd_we,
    output logic [23:0] o_cmd_addr,
    output logic [15:0] o_cmd_wdata,
    input  logic        i_rd_vld,
    input  logic [15:0] i_rd_data,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_vld,
    input  logic        i_tx_rdy,
    output logic        o_err,
    output logic        o_drop
);

    localparam int CW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

    dec_state_t    state;
    logic [CW-1:0] to_cnt;
    psram_data_t   rd_q;
    logic          in_frame;
    logic          busy;
    logic          to_hit;

    assign in_frame = (state == ADDR0) || (state == ADDR1) || (state == ADDR2) ||
                      (state == DATA0) || (state == DATA1);
    assign busy     = (state == ISSUE) || (state == WAIT_RD) ||
                      (state == TX_LO) || (state == TX_HI);
    // A byte arriving on the terminal-count cycle takes priority over the abort.
    assign to_hit   = in_frame && !i_rx_vld && (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= IDLE;
            to_cnt      <= '0;
            o_cmd_we    <= 1'b0;
            o_cmd_addr  <= '0;
            o_cmd_wdata <= '0;
            rd_q        <= '0;
            o_err       <= 1'b0;
            o_drop      <= 1'b0;
        end else begin
            o_err  <= 1'b0;
            o_drop <= busy && i_rx_vld;

            if (in_frame && !i_rx_vld && !to_hit) to_cnt <= to_cnt + CW'(1);
            else                                  to_cnt <= '0;

            if (to_hit) begin
                state       <= IDLE;
                o_err       <= 1'b1;
                o_cmd_addr  <= '0;
                o_cmd_wdata <= '0;
            end else begin
                case (state)
                    IDLE: if (i_rx_vld) begin
                        if (is_opcode(i_rx_data)) begin
                            state    <= ADDR0;
                            o_cmd_we <= i_rx_data[0];
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                    ADDR0: if (i_rx_vld) begin
                        o_cmd_addr[7:0] <= i_rx_data;
                        state           <= ADDR1;
                    end
                    ADDR1: if (i_rx_vld) begin
                        o_cmd_addr[15:8] <= i_rx_data;
                        state            <= ADDR2;
                    end
                    ADDR2: if (i_rx_vld) begin
                        o_cmd_addr[23:16] <= i_rx_data;
                        state             <= o_cmd_we ? DATA0 : ISSUE;
                    end
                    DATA0: if (i_rx_vld) begin
                        o_cmd_wdata[7:0] <= i_rx_data;
                        state            <= DATA1;
                    end
                    DATA1: if (i_rx_vld) begin
                        o_cmd_wdata[15:8] <= i_rx_data;
                        state             <= ISSUE;
                    end
                    ISSUE:   if (i_cmd_rdy) state <= o_cmd_we ? IDLE : WAIT_RD;
                    WAIT_RD: if (i_rd_vld) begin
                        rd_q  <= i_rd_data;
                        state <= TX_LO;
                    end
                    TX_LO:   if (i_tx_rdy) state <= TX_HI;
                    TX_HI:   if (i_tx_rdy) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign o_cmd_vld = (state == ISSUE);
    assign o_tx_vld  = (state == TX_LO) || (state == TX_HI);

    always_comb begin
        o_tx_data = 8'h00;
        if (state == TX_LO)      o_tx_data = rd_q[7:0];
        else if (state == TX_HI) o_tx_data = rd_q[15:8];
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed self-checking bench for uart_cmd_decoder.
module tb_uart_cmd_decoder;

    localparam int T = 20_000;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [7:0]  i_rx_data;
    logic        i_rx_vld;
    logic        o_cmd_vld;
    logic        i_cmd_rdy;
    logic        o_cmd_we;
    logic [23:0] o_cmd_addr;
    logic [15:0] o_cmd_wdata;
    logic        i_rd_vld;
    logic [15:0] i_rd_data;
    logic [7:0]  o_tx_data;
    logic        o_tx_vld;
    logic        i_tx_rdy;
    logic        o_err;
    logic        o_drop;

    int n_checks = 0;
    int n_err    = 0;

    int          xfer_cnt = 0;
    logic        xfer_we;
    logic [23:0] xfer_addr;
    logic [15:0] xfer_wdata;
    int          err_cnt  = 0;
    int          drop_cnt = 0;

    always #50 clk = ~clk;

    uart_cmd_decoder #(.TIMEOUT_CYC(T)) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .i_rx_data   (i_rx_data),
        .i_rx_vld    (i_rx_vld),
        .o_cmd_vld   (o_cmd_vld),
        .i_cmd_rdy   (i_cmd_rdy),
        .o_cmd_we    (o_cmd_we),
        .o_cmd_addr  (o_cmd_addr),
        .o_cmd_wdata (o_cmd_wdata),
        .i_rd_vld    (i_rd_vld),
        .i_rd_data   (i_rd_data),
        .o_tx_data   (o_tx_data),
        .o_tx_vld    (o_tx_vld),
        .i_tx_rdy    (i_tx_rdy),
        .o_err       (o_err),
        .o_drop      (o_drop)
    );

    always @(posedge clk) begin
        if (o_cmd_vld && i_cmd_rdy) begin
            xfer_cnt   <= xfer_cnt + 1;
            xfer_we    <= o_cmd_we;
            xfer_addr  <= o_cmd_addr;
            xfer_wdata <= o_cmd_wdata;
        end
        if (o_err)  err_cnt  <= err_cnt + 1;
        if (o_drop) drop_cnt <= drop_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the byte is sampled on the following posedge.
    task automatic send_byte(input logic [7:0] b);
        i_rx_data = b;
        i_rx_vld  = 1'b1;
        @(negedge clk);
        i_rx_vld  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [23:0] a, input logic [15:0] wd);
        send_byte(op);
        send_byte(a[7:0]);
        send_byte(a[15:8]);
        send_byte(a[23:16]);
        if (op == 8'h01) begin
            send_byte(wd[7:0]);
            send_byte(wd[15:8]);
        end
    endtask

    task automatic wait_xfer(input int prev, input string tag);
        int b = 0;
        while (xfer_cnt == prev && b < 100) begin
            @(negedge clk);
            b++;
        end
        chk(tag, xfer_cnt, prev + 1);
    endtask

    task automatic do_write(input logic [23:0] a, input logic [15:0] wd, input string tag);
        int prev = xfer_cnt;
        i_cmd_rdy = 1'b1;
        send_frame(8'h01, a, wd);
        wait_xfer(prev, {tag, "_xfer"});
        chk({tag, "_we"}, xfer_we, 1);
        chk({tag, "_addr"}, xfer_addr, a);
        chk({tag, "_wdata"}, xfer_wdata, wd);
        cyc(1);
        chk({tag, "_vld_drop"}, o_cmd_vld, 0);
        chk({tag, "_no_tx"}, o_tx_vld, 0);
    endtask

    task automatic do_read(input logic [23:0] a, input logic [15:0] rv, input string tag);
        int prev = xfer_cnt;
        i_cmd_rdy = 1'b1;
        send_frame(8'h00, a, 16'h0000);
        wait_xfer(prev, {tag, "_xfer"});
        chk({tag, "_we"}, xfer_we, 0);
        chk({tag, "_addr"}, xfer_addr, a);
        cyc(4);
        chk({tag, "_no_tx_yet"}, o_tx_vld, 0);
        i_rd_data = rv;
        i_rd_vld  = 1'b1;
        @(negedge clk);
        i_rd_vld  = 1'b0;
        chk({tag, "_lo_vld"}, o_tx_vld, 1);
        chk({tag, "_lo"}, o_tx_data, rv[7:0]);
        cyc(3);
        chk({tag, "_lo_hold"}, o_tx_data, rv[7:0]);
        i_tx_rdy = 1'b1;
        @(negedge clk);
        i_tx_rdy = 1'b0;
        chk({tag, "_hi_vld"}, o_tx_vld, 1);
        chk({tag, "_hi"}, o_tx_data, rv[15:8]);
        cyc(2);
        chk({tag, "_hi_hold"}, o_tx_data, rv[15:8]);
        i_tx_rdy = 1'b1;
        @(negedge clk);
        i_tx_rdy = 1'b0;
        chk({tag, "_tx_done"}, o_tx_vld, 0);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        int e0;
        int d0;

        arst_n    = 1'b0;
        i_rx_data = 8'h00;
        i_rx_vld  = 1'b0;
        i_cmd_rdy = 1'b0;
        i_rd_vld  = 1'b0;
        i_rd_data = 16'h0000;
        i_tx_rdy  = 1'b0;
        cyc(3);
        chk("rst_cmd_vld", o_cmd_vld, 0);
        chk("rst_we", o_cmd_we, 0);
        chk("rst_addr", o_cmd_addr, 0);
        chk("rst_wdata", o_cmd_wdata, 0);
        chk("rst_tx", {o_tx_vld, o_tx_data}, 0);
        chk("rst_err_drop", {o_err, o_drop}, 0);
        arst_n = 1'b1;
        cyc(2);

        // 1: write
        do_write(24'h040302, 16'h0708, "t1");

        // 2: read
        do_read(24'h040302, 16'h0708, "t2");

        // stray read data and tx_rdy while idle have no effect
        i_rd_vld = 1'b1; i_rd_data = 16'hDEAD; i_tx_rdy = 1'b1;
        @(negedge clk);
        i_rd_vld = 1'b0; i_tx_rdy = 1'b0;
        cyc(1);
        chk("stray_tx_vld", o_tx_vld, 0);
        chk("stray_cmd_vld", o_cmd_vld, 0);

        // 3: backpressure
        i_cmd_rdy = 1'b0;
        prev = xfer_cnt;
        send_frame(8'h01, 24'hCCBBAA, 16'h2211);
        for (int i = 0; i < 50; i++) begin
            chk("bp_vld", o_cmd_vld, 1);
            chk("bp_addr", o_cmd_addr, 24'hCCBBAA);
            chk("bp_wdata", o_cmd_wdata, 16'h2211);
            chk("bp_we", o_cmd_we, 1);
            @(negedge clk);
        end
        chk("bp_no_xfer", xfer_cnt, prev);
        i_cmd_rdy = 1'b1;
        @(negedge clk);
        i_cmd_rdy = 1'b0;
        chk("bp_one_xfer", xfer_cnt, prev + 1);
        chk("bp_xfer_addr", xfer_addr, 24'hCCBBAA);
        chk("bp_xfer_wdata", xfer_wdata, 16'h2211);
        cyc(3);
        chk("bp_vld_low", o_cmd_vld, 0);
        chk("bp_still_one", xfer_cnt, prev + 1);

        // 4: bad opcode, then drops while busy
        send_byte(8'h55);
        chk("bad_op_err", o_err, 1);
        cyc(1);
        chk("bad_op_err_pulse", o_err, 0);
        chk("bad_op_idle", o_cmd_vld, 0);
        do_write(24'h040302, 16'h0708, "t4w");

        i_cmd_rdy = 1'b1;
        prev = xfer_cnt;
        send_frame(8'h00, 24'h302010, 16'h0000);
        wait_xfer(prev, "t4_rd_xfer");
        cyc(2);
        d0 = drop_cnt;
        send_byte(8'h99);
        chk("drop_wait_rd", o_drop, 1);
        chk("drop_wait_rd_no_tx", o_tx_vld, 0);
        cyc(1);
        chk("drop_pulse", o_drop, 0);
        chk("drop_count", drop_cnt, d0 + 1);
        i_rd_data = 16'hBEEF;
        i_rd_vld  = 1'b1;
        @(negedge clk);
        i_rd_vld  = 1'b0;
        chk("t4_lo", o_tx_data, 8'hEF);
        send_byte(8'h77);
        chk("drop_tx_lo", o_drop, 1);
        chk("drop_tx_lo_data", o_tx_data, 8'hEF);
        chk("drop_tx_lo_vld", o_tx_vld, 1);
        i_tx_rdy = 1'b1;
        @(negedge clk);
        i_tx_rdy = 1'b0;
        chk("t4_hi", o_tx_data, 8'hBE);
        i_tx_rdy = 1'b1;
        @(negedge clk);
        i_tx_rdy = 1'b0;
        chk("t4_done", o_tx_vld, 0);

        // 5: inter-byte timeout at the exact terminal count
        send_byte(8'h01);
        send_byte(8'h02);
        cyc(T - 1);
        chk("to_not_yet", o_err, 0);
        cyc(1);
        chk("to_err", o_err, 1);
        chk("to_addr_cleared", o_cmd_addr, 0);
        cyc(1);
        chk("to_err_pulse", o_err, 0);
        do_write(24'hC3B2A1, 16'hE5D4, "t5w");

        // byte arriving on the terminal-count cycle wins
        e0 = err_cnt;
        prev = xfer_cnt;
        i_cmd_rdy = 1'b1;
        send_byte(8'h01);
        send_byte(8'h02);
        cyc(T - 1);
        send_byte(8'h03);
        chk("to_race_no_err", o_err, 0);
        send_byte(8'h04);
        send_byte(8'h11);
        send_byte(8'h22);
        wait_xfer(prev, "to_race_xfer");
        chk("to_race_addr", xfer_addr, 24'h040302);
        chk("to_race_wdata", xfer_wdata, 16'h2211);
        chk("to_race_err_cnt", err_cnt, e0);

        // 6: reset mid-frame
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        arst_n = 1'b0;
        #1;
        chk("mid_rst_addr", o_cmd_addr, 0);
        chk("mid_rst_we", o_cmd_we, 0);
        chk("mid_rst_vld", {o_cmd_vld, o_tx_vld, o_err, o_drop}, 0);
        cyc(2);
        arst_n = 1'b1;
        cyc(1);
        do_read(24'h040302, 16'h0708, "t6r");

        // 7: back-to-back write/read pairs
        e0 = err_cnt;
        d0 = drop_cnt;
        for (int i = 0; i < 10; i++) begin
            do_write(24'h040302, 16'h0708, "t7w");
            do_read(24'h040302, 16'h0708, "t7r");
        end
        chk("t7_no_err", err_cnt, e0);
        chk("t7_no_drop", drop_cnt, d0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
